regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised RV32I integer register file for the pipelined core.
//  - NUM_RD read ports, one write port.
//  - Optional write-to-read bypass; x0 hardwired to zero.
//  - Per-register pending (scoreboard) bits: set when an instruction with a destination issues, cleared at its writeback.
//  Sits between decode (reads, issue) and writeback; decode stalls on rs_busy.
// PARAMETERS
//  XLEN    32  data width in bits
//  NREGS   32  number of architectural registers (power of 2, >=2)
//  NUM_RD  2   number of read ports
//  BYPASS  1   1: same-cycle writeback forwarded to reads; 0: reads see array only
// PORTS
//  clk         in   1                clock, all state updates on rising edge
//  rst_n       in   1                asynchronous active-low reset
//  rs_addr     in   NUM_RD*AW        packed read addresses, port i at [i*AW +: AW], AW=$clog2(NREGS)
//  rs_data     out  NUM_RD*XLEN      packed read data, combinational
//  rs_busy     out  NUM_RD           1 = source register has a pending write
//  issue_valid in   1                instruction with a destination issues this cycle
//  issue_rd    in   AW               destination of the issuing instruction
//  wb_valid    in   1                writeback this cycle
//  wb_rd       in   AW               writeback destination
//  wb_data     in   XLEN             writeback data
//  flush       in   1                pipeline flush: clear all pending bits
//  busy_vec    out  NREGS            pending bit per register (debug/perf)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers = 0, all pending bits = 0.
//    Outputs: rs_data = 0, rs_busy = 0, busy_vec = 0 while reset is held.
//  - Read, combinational, 0-cycle latency:
//    - rs_addr==0 -> data 0, busy 0.
//    - Else if BYPASS and wb_valid and wb_rd==rs_addr -> wb_data.
//    - Else the array value.
//  - Write: on posedge with wb_valid and wb_rd!=0, reg[wb_rd] <= wb_data. Writes to x0 are dropped.
//  - Pending bits, next state per reg r (r!=0):
//    - flush: 0, overriding everything, including a same-cycle issue.
//    - Else issue_valid and issue_rd==r: 1. Issue wins over a same-cycle writeback to r (WAW: the newer producer is still pending).
//    - Else wb_valid and wb_rd==r: 0.
//    - Else hold.
//    - pending[0] is always 0; issue_rd==0 sets nothing.
//  - rs_busy[i] = pending[rs_addr[i]], except it is 0 when rs_addr==0.
//    With BYPASS, it is also 0 when wb_valid and wb_rd==rs_addr[i] in that cycle.
//  - A writeback to a non-pending register is legal: data is written, pending is unchanged.
//  - Flush does not alter register contents; a writeback in the flush cycle still writes the array.
//  - Reset asserted mid-operation clears everything immediately; the first edge after deassert behaves as from reset.
// STRUCTURE
//  - Shared package rv_pkg:
//    - XLEN_DEF = 32, NREGS_DEF = 32.
//    - typedef logic [4:0] reg_idx_t.
//    - typedef logic [XLEN_DEF-1:0] xword_t.
//  - Sub-module reg_scoreboard:
//    - Holds the pending-bit vector and its set/clear/flush logic.
//    - Exposes busy_vec.
//  - Top level holds the data array, read muxes, bypass and the rs_busy lookup.
// TESTING
//  1. Reset: hold rst_n=0, then release. Reading x1..x31 returns 0, busy_vec=0. Writing x0=0xFFFF_FFFF leaves x0 reading 0.
//  2. Write/read: wb x5=0xDEAD_BEEF, next cycle rs_addr0=5 -> 0xDEAD_BEEF. With BYPASS=1, the same-cycle read also returns 0xDEAD_BEEF. With BYPASS=0, the same-cycle read returns the old value.
//  3. Scoreboard: issue rd=7 -> rs_busy=1 on x7 from next cycle. wb x7=0x1234 -> busy 0 after the edge (same cycle if BYPASS=1), read returns 0x1234.
//  4. Simultaneous events: x9 pending, issue rd=9 and wb x9=0x55 in the same cycle -> data=0x55, pending[9] stays 1.
//  5. Flush: pend x3, x4, x10, then flush together with issue rd=11 -> busy_vec=0; register contents unchanged.
//  6. Reset mid-op: pend x2 and write x2=0xA5, assert rst_n low between edges -> busy_vec=0 and x2=0 immediately.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: default widths and common register/word types.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage : rv_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback, wiped by a pipeline flush. Bit 0 (x0) is never pending.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic                     flush,
    output logic [NREGS-1:0]         busy_vec
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Next pending state: flush beats issue, issue beats writeback (WAW keeps the newer producer pending).
    always_comb begin
        w_pend_nxt = r_pend;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                w_pend_nxt[r] = 1'b0;
            end else if (issue_valid && (issue_rd == AW'(r))) begin
                w_pend_nxt[r] = 1'b1;
            end else if (wb_valid && (wb_rd == AW'(r))) begin
                w_pend_nxt[r] = 1'b0;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Pending-bit register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign busy_vec = r_pend;

endmodule : reg_scoreboard

// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_RD combinational read ports, one write port,
// optional writeback-to-read bypass, x0 hardwired to zero, and a per-register
// pending scoreboard that decode uses to stall on in-flight producers.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] rs_addr,
    output logic [NUM_RD*XLEN-1:0]          rs_data,
    output logic [NUM_RD-1:0]               rs_busy,
    input  logic                            issue_valid,
    input  logic [$clog2(NREGS)-1:0]        issue_rd,
    input  logic                            wb_valid,
    input  logic [$clog2(NREGS)-1:0]        wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    input  logic                            flush,
    output logic [NREGS-1:0]                busy_vec
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy_vec;

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .busy_vec    (w_busy_vec)
    );

    assign busy_vec = w_busy_vec;

    // Register array: async clear, writes to x0 are discarded (flush does not block writes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wb_valid && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Per-port read mux and busy lookup; a matching same-cycle writeback both
    // forwards its data and satisfies the dependency when bypass is enabled.
    // Reads are forced to zero while reset is held so a bypassed writeback
    // cannot leak through.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_zero;
        logic          w_hit;

        assign w_addr = rs_addr[g*AW +: AW];
        assign w_zero = (w_addr == '0);
        assign w_hit  = BYPASS && wb_valid && (wb_rd == w_addr);

        assign rs_data[g*XLEN +: XLEN] = (!rst_n || w_zero) ? '0 :
                                         w_hit              ? wb_data :
                                                              r_regs[w_addr];
        assign rs_busy[g] = !w_zero && !w_hit && w_busy_vec[w_addr];
    end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing instance and a
// non-bypassing instance share all inputs and are checked against
// hand-computed values.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [63:0] rs_data_nb;
    logic [1:0]  rs_busy;
    logic [1:0]  rs_busy_nb;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] busy_vec;
    logic [31:0] busy_vec_nb;

    int total;
    int bad;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data),
        .rs_busy(rs_busy), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .busy_vec(busy_vec)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_nb),
        .rs_busy(rs_busy_nb), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .busy_vec(busy_vec_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        flush       = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_rs(5'd0, 5'd0);
        @(negedge clk);
        set_rs(5'd1, 5'd1);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hFFFF_FFFF;
        #1;
        total++;
        if (rs_data !== 64'd0) begin
            bad++; $display("FAIL rst_rs_data got=%h exp=%h", rs_data, 64'd0);
        end
        total++;
        if (busy_vec !== 32'd0 || busy_vec_nb !== 32'd0 || rs_busy !== 2'b00) begin
            bad++; $display("FAIL rst_busy got=%h/%h/%b exp=0", busy_vec, busy_vec_nb, rs_busy);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            set_rs(5'(a), 5'(a));
            #1;
            total++;
            if (rs_data !== 64'd0 || rs_data_nb !== 64'd0) begin
                bad++; $display("FAIL rst_read_x%0d got=%h/%h exp=0", a, rs_data, rs_data_nb);
            end
        end
        total++;
        if (busy_vec !== 32'd0) begin
            bad++; $display("FAIL rst_busy_vec got=%h exp=%h", busy_vec, 32'd0);
        end
        @(negedge clk);
        set_rs(5'd0, 5'd0);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        total++;
        if (rs_data[31:0] !== 32'd0) begin
            bad++; $display("FAIL x0_bypass got=%h exp=%h", rs_data[31:0], 32'd0);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (rs_data !== 64'd0 || rs_data_nb !== 64'd0) begin
            bad++; $display("FAIL x0_write got=%h/%h exp=0", rs_data, rs_data_nb);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_rs(5'd5, 5'd5);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        total++;
        if (rs_data[31:0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL wr_bypass got=%h exp=%h", rs_data[31:0], 32'hDEAD_BEEF);
        end
        total++;
        if (rs_data_nb[31:0] !== 32'd0) begin
            bad++; $display("FAIL wr_nobypass_old got=%h exp=%h", rs_data_nb[31:0], 32'd0);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (rs_data !== {2{32'hDEAD_BEEF}} || rs_data_nb !== {2{32'hDEAD_BEEF}}) begin
            bad++; $display("FAIL wr_read got=%h/%h exp=%h", rs_data, rs_data_nb, {2{32'hDEAD_BEEF}});
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        set_rs(5'd0, 5'd7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        total++;
        if (rs_busy[1] !== 1'b0) begin
            bad++; $display("FAIL sb_issue_same got=%b exp=%b", rs_busy[1], 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (rs_busy[1] !== 1'b1 || rs_busy_nb[1] !== 1'b1) begin
            bad++; $display("FAIL sb_busy got=%b/%b exp=1", rs_busy[1], rs_busy_nb[1]);
        end
        total++;
        if (busy_vec !== 32'h0000_0080) begin
            bad++; $display("FAIL sb_busy_vec got=%h exp=%h", busy_vec, 32'h0000_0080);
        end
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_1234;
        #1;
        total++;
        if (rs_busy[1] !== 1'b0 || rs_busy_nb[1] !== 1'b1) begin
            bad++; $display("FAIL sb_wb_same got=%b/%b exp=0/1", rs_busy[1], rs_busy_nb[1]);
        end
        total++;
        if (rs_data[63:32] !== 32'h0000_1234) begin
            bad++; $display("FAIL sb_wb_fwd got=%h exp=%h", rs_data[63:32], 32'h0000_1234);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if (rs_busy !== 2'b00 || rs_busy_nb !== 2'b00 || busy_vec !== 32'd0) begin
            bad++; $display("FAIL sb_cleared got=%b/%b/%h exp=0", rs_busy, rs_busy_nb, busy_vec);
        end
        total++;
        if (rs_data_nb[63:32] !== 32'h0000_1234) begin
            bad++; $display("FAIL sb_read got=%h exp=%h", rs_data_nb[63:32], 32'h0000_1234);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        set_rs(5'd9, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0055;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0000_0055 || rs_data_nb[31:0] !== 32'h0000_0055) begin
            bad++; $display("FAIL simul_data got=%h/%h exp=%h", rs_data[31:0], rs_data_nb[31:0], 32'h55);
        end
        total++;
        if (busy_vec !== 32'h0000_0200 || rs_busy[0] !== 1'b1) begin
            bad++; $display("FAIL simul_pending got=%h/%b exp=%h/1", busy_vec, rs_busy[0], 32'h200);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_rd = 5'd4;
        @(negedge clk);
        issue_rd = 5'd10;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0000_0618) begin
            bad++; $display("FAIL flush_pre got=%h exp=%h", busy_vec, 32'h0000_0618);
        end
        @(negedge clk);
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd11;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0077;
        @(negedge clk);
        idle();
        set_rs(5'd3, 5'd5);
        #1;
        total++;
        if (busy_vec !== 32'd0 || busy_vec_nb !== 32'd0) begin
            bad++; $display("FAIL flush_busy got=%h/%h exp=0", busy_vec, busy_vec_nb);
        end
        total++;
        if (rs_data !== {32'hDEAD_BEEF, 32'h0000_0077} || rs_data_nb !== {32'hDEAD_BEEF, 32'h0000_0077}) begin
            bad++; $display("FAIL flush_data got=%h/%h exp=%h", rs_data, rs_data_nb, {32'hDEAD_BEEF, 32'h77});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0011;
        @(negedge clk);
        wb_rd = 5'd2; wb_data = 32'h0000_0022;
        @(negedge clk);
        wb_rd = 5'd3; wb_data = 32'h0000_0033;
        issue_valid = 1'b1; issue_rd = 5'd12;
        @(negedge clk);
        issue_valid = 1'b0; issue_rd = 5'd0;
        wb_rd = 5'd13; wb_data = 32'h0000_1313;
        set_rs(5'd1, 5'd2);
        #1;
        total++;
        if (rs_data_nb !== {32'h0000_0022, 32'h0000_0011}) begin
            bad++; $display("FAIL b2b_x1x2 got=%h exp=%h", rs_data_nb, {32'h22, 32'h11});
        end
        @(negedge clk);
        idle();
        set_rs(5'd3, 5'd13);
        #1;
        total++;
        if (rs_data !== {32'h0000_1313, 32'h0000_0033}) begin
            bad++; $display("FAIL b2b_x3x13 got=%h exp=%h", rs_data, {32'h1313, 32'h33});
        end
        total++;
        if (busy_vec !== 32'h0000_1000) begin
            bad++; $display("FAIL b2b_nonpending_wb got=%h exp=%h", busy_vec, 32'h0000_1000);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_00A5;
        @(negedge clk);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd2;
        @(negedge clk);
        idle();
        set_rs(5'd2, 5'd12);
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0000_00A5 || busy_vec !== 32'h0000_1004) begin
            bad++; $display("FAIL midrst_pre got=%h/%h exp=%h/%h", rs_data[31:0], busy_vec, 32'hA5, 32'h1004);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy_vec !== 32'd0 || busy_vec_nb !== 32'd0 || rs_busy !== 2'b00) begin
            bad++; $display("FAIL midrst_busy got=%h/%h/%b exp=0", busy_vec, busy_vec_nb, rs_busy);
        end
        total++;
        if (rs_data !== 64'd0 || rs_data_nb !== 64'd0) begin
            bad++; $display("FAIL midrst_data got=%h/%h exp=0", rs_data, rs_data_nb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd2;
        @(negedge clk);
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0000_0004 || rs_data[31:0] !== 32'd0) begin
            bad++; $display("FAIL midrst_after got=%h/%h exp=%h/0", busy_vec, rs_data[31:0], 32'h4);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_simultaneous();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_regfile_scoreboard
